// File: rtl/ext_loader_pkg.sv
// ---------------------------------------------------------------------------
// ext_loader_pkg
// Shared types and constants for the boot-time external memory loader:
//   - state_e           : loader FSM states
//   - BYTES_PER_WORD    : bytes assembled per stored word
//   - MAX_WORDS_DEFAULT : default largest accepted word count
//   - idx_width()       : word-index width for a given MAX_WORDS, $clog2(MAX_WORDS+1)
// ---------------------------------------------------------------------------
package ext_loader_pkg;

    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam int unsigned MAX_WORDS_DEFAULT = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_RUN
    } state_e;

    // Wide enough to hold any index 0..max_words, so idx+1 never overflows.
    function automatic int unsigned idx_width(input int unsigned max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/ext_mem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Assembles a little-endian 32-bit word from an accepted byte stream.
// Used for both the header count and the data words.
//   clk             in   clock
//   rst_n           in   asynchronous active-low reset
//   clear_i         in   return byte counter to zero (loader not collecting)
//   accept_i        in   a byte is consumed this cycle
//   byte_i          in   byte payload
//   word_o          out  word including the byte presented this cycle
//   word_complete_o out  this accept supplies the fourth byte of a word
// ---------------------------------------------------------------------------
module byte_packer
    import ext_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_complete_o
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_q, cnt_d;
    // Only the first three bytes need storing: the fourth is taken straight
    // from byte_i so the finished word is available on its accept edge.
    logic [23:0] shift_q, shift_d;

    assign word_o          = {byte_i, shift_q};
    assign word_complete_o = accept_i && (cnt_q == LAST_BYTE);

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (accept_i) begin
            cnt_d   = cnt_q + 2'd1;   // wraps to 0 after the fourth byte
            shift_d = word_o[31:8];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/ext_mem_loader.sv
// ---------------------------------------------------------------------------
// ext_mem_loader
// Boot-time loader driving the external data-memory write port. Accepts a
// byte stream (4-byte LE word count, then that many LE words), issues one
// word store per word while holding the CPU in reset, then releases it.
//   clk           in   clock
//   reset         in   asynchronous active-low reset
//   start         in   begin a load (honoured in IDLE or RUN only)
//   in_valid      in   byte-stream valid
//   in_data       in   byte-stream payload
//   in_ready      out  a byte is accepted this cycle when in_valid is high
//   Ext_MemWrite  out  word-store strobe
//   Ext_DataAdr   out  store byte address (ADDR_BASE + 4*idx)
//   Ext_WriteData out  store data
//   cpu_reset     out  active-high CPU reset, low only while running
//   busy          out  load in progress
//   done          out  last load completed, CPU running
//   err           out  header count exceeded MAX_WORDS (sticky until start)
// All outputs are registered from the next-state value so they line up with
// the state they describe.
// ---------------------------------------------------------------------------
module ext_mem_loader
    import ext_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_DataAdr,
    output logic [31:0] Ext_WriteData,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned IDX_W = idx_width(MAX_WORDS);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               mem_write_q, mem_write_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               pk_clear;
    logic               pk_accept;
    logic               pk_complete;
    logic [31:0]        pk_word;

    assign pk_accept = in_valid && in_ready_q;

    byte_packer u_packer (
        .clk             (clk),
        .rst_n           (reset),
        .clear_i         (pk_clear),
        .accept_i        (pk_accept),
        .byte_i          (in_data),
        .word_o          (pk_word),
        .word_complete_o (pk_complete)
    );

    // Next state, counters and sticky error.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        err_d    = err_q;
        pk_clear = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                pk_clear = 1'b1;
                if (start) begin
                    state_d = ST_HDR;
                    idx_d   = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_HDR: begin
                if (pk_complete) begin
                    if (pk_word == 32'd0) begin
                        state_d = ST_RUN;
                    end else if (pk_word > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        count_d = pk_word[IDX_W-1:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (pk_complete) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = (idx_d == count_q) ? ST_RUN : ST_DATA;
            end
            ST_RUN: begin
                pk_clear = 1'b1;
                if (start) begin
                    state_d = ST_HDR;
                    idx_d   = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the state being entered.
    always_comb begin
        in_ready_d  = (state_d == ST_HDR) || (state_d == ST_DATA);
        busy_d      = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_WRITE);
        done_d      = (state_d == ST_RUN);
        cpu_reset_d = (state_d != ST_RUN);
        mem_write_d = (state_d == ST_WRITE);
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        // Entering WRITE coincides with the fourth data byte, so the packer's
        // word output already holds the complete word. idx_q is still the
        // index of that word here; it advances during WRITE.
        if (state_d == ST_WRITE) begin
            addr_d  = ADDR_BASE + (32'(idx_q) << 2);
            wdata_d = pk_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign Ext_MemWrite  = mem_write_q;
    assign Ext_DataAdr   = addr_q;
    assign Ext_WriteData = wdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ext_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_ext_mem_loader
// Self-checking bench for ext_mem_loader. The reference model parses each
// byte stream directly (count, then LE words) into the list of stores the
// loader must issue; a monitor records the stores actually seen.
// ---------------------------------------------------------------------------
module tb_ext_mem_loader;

    localparam int unsigned MAXW = 256;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        start    = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_ready;
    logic        Ext_MemWrite;
    logic [31:0] Ext_DataAdr;
    logic [31:0] Ext_WriteData;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    ext_mem_loader #(
        .MAX_WORDS (MAXW),
        .ADDR_BASE (BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .Ext_MemWrite  (Ext_MemWrite),
        .Ext_DataAdr   (Ext_DataAdr),
        .Ext_WriteData (Ext_WriteData),
        .cpu_reset     (cpu_reset),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    int          n_tests   = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          wr_cycles = 0;
    logic [63:0] exp_q[$];              // {addr, data} the model expects
    logic [63:0] obs_q[$];              // {addr, data} seen on the port
    logic [7:0]  stream[$];             // byte stream being sent
    logic [31:0] mem [logic [31:0]];    // image of the external memory

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (Ext_MemWrite === 1'b1) begin
            obs_q.push_back({Ext_DataAdr, Ext_WriteData});
            mem[Ext_DataAdr] = Ext_WriteData;
            wr_cycles++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the stores implied by the bytes of `stream`.
    function automatic void model_load();
        logic [31:0] cnt;
        int unsigned b;
        if (stream.size() < 4) return;
        cnt = {stream[3], stream[2], stream[1], stream[0]};
        if (cnt == 0 || cnt > MAXW) return;
        for (int unsigned i = 0; i < cnt; i++) begin
            b = 4 + 4 * i;
            if (b + 3 < stream.size())
                exp_q.push_back({BASE + 32'(4 * i),
                                 stream[b+3], stream[b+2], stream[b+1], stream[b]});
        end
    endfunction

    function automatic void push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
    endfunction

    task automatic clear_scoreboard();
        exp_q.delete();
        obs_q.delete();
        stream.delete();
        wr_cycles = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int n;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = ($urandom_range(0, 3) == 0);   // must be ignored mid-load
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
    endtask

    task automatic send_stream(input int max_gap, output int t_first);
        t_first = 0;
        foreach (stream[i]) begin
            send_byte(stream[i], max_gap);
            if (i == 0) t_first = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_settle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check({tag, "_busy_timeout"}, {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_stores(input string tag);
        check({tag, "_nstores"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check({tag, "_store"}, obs_q[i], exp_q[i]);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  {63'd0, in_ready},     64'd0);
        check({tag, "_memwrite"},  {63'd0, Ext_MemWrite}, 64'd0);
        check({tag, "_adr"},       {32'd0, Ext_DataAdr},  64'd0);
        check({tag, "_wdata"},     {32'd0, Ext_WriteData}, 64'd0);
        check({tag, "_cpu_reset"}, {63'd0, cpu_reset},    64'd1);
        check({tag, "_busy"},      {63'd0, busy},         64'd0);
        check({tag, "_done"},      {63'd0, done},         64'd0);
        check({tag, "_err"},       {63'd0, err},          64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        logic        seen;
        logic [31:0] cnt;
        int unsigned r;
        int unsigned nw;
        logic        ok;

        // ---- reset and idle ------------------------------------------------
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");
        seen = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            seen |= in_ready;
        end
        in_valid = 1'b0;
        check("idle_no_ready", {63'd0, seen}, 64'd0);
        check("idle_no_store", 64'(obs_q.size()), 64'd0);

        // ---- single word, full throughput ----------------------------------
        clear_scoreboard();
        pulse_start();
        push_word(32'd1);
        push_word(32'h1234_5678);
        model_load();
        send_stream(0, t0);
        check("one_memwrite",  {63'd0, Ext_MemWrite}, 64'd1);
        check("one_adr",       {32'd0, Ext_DataAdr},  {32'd0, BASE});
        check("one_wdata",     {32'd0, Ext_WriteData}, 64'h1234_5678);
        check("one_cpu_rst_w", {63'd0, cpu_reset},    64'd1);
        @(negedge clk);
        check("one_memwrite_off", {63'd0, Ext_MemWrite}, 64'd0);
        check("one_cpu_reset",    {63'd0, cpu_reset},    64'd0);
        check("one_done",         {63'd0, done},         64'd1);
        check("one_busy",         {63'd0, busy},         64'd0);
        // 4+5n+1 cycles counted inclusively span (4+5n+1)-2 edges after the first accept.
        check("one_latency", 64'(cyc - t0), 64'((4 + 5 * 1 + 1) - 2));
        check("one_hold_adr", {32'd0, Ext_DataAdr}, {32'd0, BASE});
        check_stores("one");

        // ---- three words with random gaps ----------------------------------
        clear_scoreboard();
        pulse_start();
        push_word(32'd3);
        for (int i = 0; i < 3; i++) push_word($urandom);
        model_load();
        send_stream(3, t0);
        wait_settle("three");
        check("three_wr_cycles", 64'(wr_cycles), 64'd3);
        check("three_done",      {63'd0, done},  64'd1);
        check_stores("three");

        // ---- zero count ----------------------------------------------------
        clear_scoreboard();
        pulse_start();
        push_word(32'd0);
        send_stream(0, t0);
        check("zero_cpu_reset", {63'd0, cpu_reset}, 64'd0);
        check("zero_done",      {63'd0, done},      64'd1);
        check("zero_in_ready",  {63'd0, in_ready},  64'd0);
        repeat (2) @(negedge clk);
        check("zero_nstores", 64'(obs_q.size()), 64'd0);

        // ---- count just above the limit ------------------------------------
        clear_scoreboard();
        pulse_start();
        push_word(MAXW + 1);
        send_stream(0, t0);
        check("err_flag",      {63'd0, err},       64'd1);
        check("err_in_ready",  {63'd0, in_ready},  64'd0);
        check("err_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("err_busy",      {63'd0, busy},      64'd0);
        check("err_done",      {63'd0, done},      64'd0);
        seen = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            seen |= in_ready;
        end
        in_valid = 1'b0;
        check("err_no_ready",  {63'd0, seen}, 64'd0);
        check("err_sticky",    {63'd0, err},  64'd1);
        check("err_nstores",   64'(obs_q.size()), 64'd0);

        // ---- reset in the middle of a word ---------------------------------
        clear_scoreboard();
        pulse_start();
        push_word(32'd2);
        stream.push_back(8'($urandom));
        stream.push_back(8'($urandom));
        send_stream(0, t0);
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_nstores", 64'(obs_q.size()), 64'd0);

        clear_scoreboard();
        pulse_start();
        push_word(32'd2);
        push_word($urandom);
        push_word($urandom);
        model_load();
        send_stream(2, t0);
        wait_settle("after_rst");
        check("after_rst_done", {63'd0, done}, 64'd1);
        check_stores("after_rst");

        // ---- restart from RUN overwrites earlier words ---------------------
        clear_scoreboard();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rerun_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("rerun_done",      {63'd0, done},      64'd0);
        check("rerun_in_ready",  {63'd0, in_ready},  64'd1);
        push_word(32'd2);
        push_word($urandom);
        push_word($urandom);
        model_load();
        send_stream(1, t0);
        wait_settle("rerun");
        check_stores("rerun");
        foreach (exp_q[i])
            check("rerun_mem", {32'd0, mem[exp_q[i][63:32]]}, {32'd0, exp_q[i][31:0]});

        // ---- randomized loads ----------------------------------------------
        for (int it = 0; it < 10; it++) begin
            clear_scoreboard();
            r = $urandom_range(0, 9);
            if (r == 0)      cnt = 32'd0;
            else if (r == 1) cnt = MAXW + 1 + $urandom_range(0, 1000);
            else if (r == 2) cnt = 32'hFFFF_FFFF;
            else             cnt = $urandom_range(1, 6);
            ok = (cnt <= MAXW);
            nw = ok ? cnt : 0;
            pulse_start();
            push_word(cnt);
            for (int unsigned k = 0; k < nw; k++) push_word($urandom);
            model_load();
            send_stream(int'($urandom_range(0, 3)), t0);
            wait_settle("rand");
            check_stores("rand");
            check("rand_done",      {63'd0, done},      {63'd0, ok});
            check("rand_err",       {63'd0, err},       {63'd0, !ok});
            check("rand_cpu_reset", {63'd0, cpu_reset}, {63'd0, !ok});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
